// File: rtl/nios_debug_jtag_scan_master.sv
// Nios II debug JTAG scan master: optional IR scan then N-bit DR scan per command.
// Define DEBUG_SCAN_READBACK_EN to keep the TDO capture register; otherwise rsp_dr is tied to 0.
module nios_debug_jtag_scan_master #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned DR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ir_en,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [5:0]          cmd_len,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [5:0]      IrLast  = 6'(IR_WIDTH - 1);
    localparam logic [5:0]      DrMax   = 6'(DR_WIDTH);

    typedef enum logic [3:0] {
        StRstSeq, StIdle, StIrHead, StIrShift, StIrTail, StDrHead, StDrShift, StDrTail, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d, len_q, len_d, seg_last;
    logic [DivW-1:0]     div_q, div_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DR_WIDTH-1:0] dr_q, dr_d;
    logic                scanning, phase_end, bit_end, tck_rise, accept;

    assign scanning  = (state_q != StIdle) && (state_q != StDone);
    assign phase_end = scanning && (div_q == DivLast);
    assign bit_end   = phase_end && tck_q;
    assign tck_rise  = phase_end && !tck_q;
    assign accept    = (state_q == StIdle) && cmd_valid;

    // Index of the last TCK bit of the current segment.
    always_comb begin
        seg_last = 6'd0;
        case (state_q)
            StRstSeq:  seg_last = 6'd5;
            StIrHead:  seg_last = 6'd3;
            StIrShift: seg_last = IrLast;
            StIrTail:  seg_last = 6'd1;
            StDrHead:  seg_last = 6'd2;
            StDrShift: seg_last = len_q - 6'd1;
            StDrTail:  seg_last = 6'd1;
            default:   seg_last = 6'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRstSeq;
            cnt_q   <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            len_q   <= '0;
            ir_q    <= '0;
            dr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tck_d   = tck_q;
        len_d   = len_q;
        ir_d    = ir_q;
        dr_d    = dr_q;
        if (scanning) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
            if (phase_end) tck_d = ~tck_q;
        end
        if (bit_end) begin
            cnt_d = cnt_q + 6'd1;
            if (state_q == StIrShift) ir_d = ir_q >> 1;
            if (state_q == StDrShift) dr_d = dr_q >> 1;
            if (cnt_q == seg_last) begin
                cnt_d = '0;
                case (state_q)
                    StRstSeq:  state_d = StIdle;
                    StIrHead:  state_d = StIrShift;
                    StIrShift: state_d = StIrTail;
                    StIrTail:  state_d = (len_q != 6'd0) ? StDrHead : StDone;
                    StDrHead:  state_d = StDrShift;
                    StDrShift: state_d = StDrTail;
                    StDrTail:  state_d = StDone;
                    default:   state_d = StIdle;
                endcase
            end
        end
        if (accept) begin
            len_d   = (cmd_len > DrMax) ? DrMax : cmd_len;
            ir_d    = cmd_ir;
            dr_d    = cmd_dr;
            cnt_d   = '0;
            div_d   = '0;
            state_d = cmd_ir_en ? StIrHead : ((len_d != 6'd0) ? StDrHead : StDone);
        end
        if (state_q == StDone) state_d = StIdle;
    end

    // TMS/TDI are registered from the next state so they change with the falling TCK edge.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = !cmd_ready;
        rsp_valid = (state_q == StDone);
        tms_d     = 1'b0;
        case (state_d)
            StRstSeq:  tms_d = (cnt_d != 6'd5);
            StIrHead:  tms_d = (cnt_d < 6'd2);
            StIrShift: tms_d = (cnt_d == IrLast);
            StIrTail:  tms_d = (cnt_d == 6'd0);
            StDrHead:  tms_d = (cnt_d == 6'd0);
            StDrShift: tms_d = (cnt_d == len_d - 6'd1);
            StDrTail:  tms_d = (cnt_d == 6'd0);
            default:   tms_d = 1'b0;
        endcase
        tdi_d = 1'b0;
        if (state_d == StIrShift) tdi_d = ir_d[0];
        if (state_d == StDrShift) tdi_d = dr_d[0];
    end

    assign tck = tck_q;
    assign tms = tms_q;
    assign tdi = tdi_q;

`ifdef DEBUG_SCAN_READBACK_EN
    logic [DR_WIDTH-1:0] cap_q, cap_d, rsp_dr_q;

    always_comb begin
        cap_d = cap_q;
        if (accept) begin
            cap_d = '0;
        end else if (tck_rise && (state_q == StDrShift)) begin
            for (int i = 0; i < DR_WIDTH; i++) begin
                if (cnt_q == 6'(i)) cap_d[i] = tdo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q    <= '0;
            rsp_dr_q <= '0;
        end else begin
            cap_q <= cap_d;
            if (state_d == StDone) rsp_dr_q <= cap_d;
        end
    end

    assign rsp_dr = rsp_dr_q;
`else
    logic unused_tdo;
    logic unused_rise;
    assign unused_tdo  = tdo;
    assign unused_rise = tck_rise;
    assign rsp_dr      = '0;
`endif

endmodule

// File: tb/tb_nios_debug_jtag_scan_master.sv
// Randomized bench for nios_debug_jtag_scan_master against a per-TCK-bit reference model.
// Expected rsp_dr follows DEBUG_SCAN_READBACK_EN the same way the design does.
module tb_nios_debug_jtag_scan_master;
    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned IR_WIDTH = 2;
    localparam int unsigned DR_WIDTH = 38;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ir_en = 1'b0;
    logic [IR_WIDTH-1:0] cmd_ir = '0;
    logic [5:0]          cmd_len = '0;
    logic [DR_WIDTH-1:0] cmd_dr = '0;
    logic                cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [1:0]          tdo_mode = 2'd0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int period_err = 0;
    int first_rise = -1;
    int last_rise = -1;
    logic tck_prev = 1'b0;
    bit obs_tms[$];
    bit obs_tdi[$];

    nios_debug_jtag_scan_master #(
        .CLK_DIV (CLK_DIV),
        .IR_WIDTH(IR_WIDTH),
        .DR_WIDTH(DR_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir_en(cmd_ir_en),
        .cmd_ir   (cmd_ir),
        .cmd_len  (cmd_len),
        .cmd_dr   (cmd_dr),
        .rsp_valid(rsp_valid),
        .rsp_dr   (rsp_dr),
        .busy     (busy),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: loopback, 1: tied high, 2: tied low, 3: inverted loopback
    always_comb begin
        case (tdo_mode)
            2'd0:    tdo = tdi;
            2'd1:    tdo = 1'b1;
            2'd2:    tdo = 1'b0;
            default: tdo = ~tdi;
        endcase
    end

    // Record TMS/TDI at every TCK rise and the spacing between rises.
    always @(negedge clk) begin
        if (tck === 1'b1 && tck_prev === 1'b0) begin
            obs_tms.push_back(tms);
            obs_tdi.push_back(tdi);
            if (first_rise < 0) first_rise = cyc;
            else if (cyc - last_rise != int'(2 * CLK_DIV)) period_err++;
            last_rise = cyc;
        end
        tck_prev = tck;
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_bits(input bit q[$]);
        logic [63:0] v = '0;
        for (int k = 0; k < q.size() && k < 64; k++) v[k] = q[k];
        return v;
    endfunction

    task automatic clear_obs();
        obs_tms.delete();
        obs_tdi.delete();
        first_rise = -1;
        last_rise  = -1;
        period_err = 0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 400) begin
            @(posedge clk); #1; t++;
        end
        check_eq("ready_before_cmd", cmd_ready, 1);
    endtask

    // Hold reset, release it, then follow the 6-TCK reset sequence into idle.
    task automatic do_reset(input int hold);
        int t, rsp0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
        rsp0 = rsp_cnt;
        check_eq("rst_outputs", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010010);
        check_eq("rst_rsp_dr", rsp_dr, 0);
        t = 1;
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check_eq("rst_ready_cycle", t, 6 * 2 * CLK_DIV + 1);
        check_eq("rst_tck_bits", obs_tms.size(), 6);
        check_eq("rst_tms_seq", pack_bits(obs_tms), 64'h1F);
        check_eq("rst_busy_low", busy, 0);
        check_eq("rst_no_rsp", rsp_cnt - rsp0, 0);
    endtask

    task automatic run_cmd(input logic ir_en, input logic [IR_WIDTH-1:0] ir, input logic [5:0] len,
                           input logic [DR_WIDTH-1:0] dr, input logic [1:0] mode);
        bit          etms[$];
        bit          etdi[$];
        int          elen, nbits, t, acc_cyc, rsp0, exp_first;
        logic [63:0] mask, exp_rsp, r64;
        elen = (len > DR_WIDTH) ? DR_WIDTH : int'(len);
        if (ir_en) begin
            etms.push_back(1); etms.push_back(1); etms.push_back(0); etms.push_back(0);
            repeat (4) etdi.push_back(0);
            for (int i = 0; i < IR_WIDTH; i++) begin
                etms.push_back(i == IR_WIDTH - 1);
                etdi.push_back(ir[i]);
            end
            etms.push_back(1); etms.push_back(0);
            repeat (2) etdi.push_back(0);
        end
        if (elen > 0) begin
            etms.push_back(1); etms.push_back(0); etms.push_back(0);
            repeat (3) etdi.push_back(0);
            for (int i = 0; i < elen; i++) begin
                etms.push_back(i == elen - 1);
                etdi.push_back(dr[i]);
            end
            etms.push_back(1); etms.push_back(0);
            repeat (2) etdi.push_back(0);
        end
        nbits = etms.size();
        mask  = (elen == 0) ? 64'd0 : (64'd1 << elen) - 64'd1;
`ifdef DEBUG_SCAN_READBACK_EN
        case (mode)
            2'd0:    exp_rsp = 64'(dr) & mask;
            2'd1:    exp_rsp = mask;
            2'd2:    exp_rsp = 64'd0;
            default: exp_rsp = ~64'(dr) & mask;
        endcase
`else
        exp_rsp = 64'd0;
`endif
        wait_ready();
        tdo_mode  = mode;
        cmd_valid = 1'b1;
        cmd_ir_en = ir_en;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_dr    = dr;
        rsp0      = rsp_cnt;
        @(posedge clk); #1;
        clear_obs();
        acc_cyc = cyc;
        // Garbage commands offered while busy must be ignored.
        r64       = {$urandom(), $urandom()};
        cmd_valid = (nbits > 0);
        cmd_ir_en = r64[63];
        cmd_ir    = r64[62 -: IR_WIDTH];
        cmd_len   = r64[45:40];
        cmd_dr    = r64[DR_WIDTH-1:0];
        t = 1;
        while (rsp_valid !== 1'b1 && t < 600) begin
            @(posedge clk); #1; t++;
            if (t > 3) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        exp_first = (nbits > 0) ? acc_cyc + int'(CLK_DIV) : -1;
        check_eq("latency", t, 2 * CLK_DIV * nbits + 1);
        check_eq("rsp_dr", rsp_dr, exp_rsp);
        check_eq("ready_in_done", cmd_ready, 0);
        check_eq("tck_bits", obs_tms.size(), nbits);
        check_eq("tms_seq", pack_bits(obs_tms), pack_bits(etms));
        check_eq("tdi_seq", pack_bits(obs_tdi), pack_bits(etdi));
        check_eq("tck_period", period_err, 0);
        check_eq("first_rise", first_rise, exp_first);
        @(posedge clk); #1;
        check_eq("rsp_one_cycle", rsp_valid, 0);
        check_eq("ready_after", cmd_ready, 1);
        check_eq("rsp_dr_hold", rsp_dr, exp_rsp);
        check_eq("rsp_count", rsp_cnt - rsp0, 1);
        check_eq("rti_rest", {tck, tms, tdi}, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, sel;
        logic [5:0]  l;
        logic [63:0] r64;
        do_reset(3);
        run_cmd(1'b0, 2'b00, 6'd38, 38'h2A_5555_AAAA, 2'd0);
        run_cmd(1'b1, 2'b10, 6'd8, 38'hC3, 2'd1);
        run_cmd(1'b0, 2'b00, 6'd50, 38'h3F_0F0F_1234, 2'd0);
        run_cmd(1'b0, 2'b00, 6'd0, 38'h12_3456_789A, 2'd0);
        run_cmd(1'b1, 2'b01, 6'd0, 38'h0, 2'd1);

        // Reset during DR shift bit 10: scan is abandoned and the TAP re-initialised.
        wait_ready();
        tdo_mode  = 2'd0;
        cmd_valid = 1'b1;
        cmd_ir_en = 1'b0;
        cmd_len   = 6'd38;
        cmd_dr    = 38'h15_AAAA_5555;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        clear_obs();
        t = 0;
        while (obs_tms.size() < 14 && t < 400) begin
            @(posedge clk); #1; t++;
        end
        check_eq("abort_point", obs_tms.size(), 14);
        do_reset(2);
        run_cmd(1'b0, 2'b00, 6'd38, 38'h2A_5555_AAAA, 2'd0);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       l = 6'd0;
                1:       l = 6'd1;
                2:       l = 6'd38;
                3:       l = 6'($urandom_range(39, 63));
                default: l = 6'($urandom_range(2, 37));
            endcase
            r64 = {$urandom(), $urandom()};
            run_cmd(r64[63], r64[61:60], l, r64[DR_WIDTH-1:0], 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
